// File: rtl/pixel_stream_pkg.sv
// Shared constants for the pixel stream: word geometry, packer states and
// the layout of one buffered output word.
package pixel_stream_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int DATA_W         = 8 * BYTES_PER_WORD;
  localparam int KEEP_W         = BYTES_PER_WORD;

  // FIFO entry layout {last, keep, data}
  localparam int DATA_OFF = 0;
  localparam int KEEP_OFF = DATA_W;
  localparam int LAST_OFF = DATA_W + KEEP_W;
  localparam int ENTRY_W  = DATA_W + KEEP_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_t;

  // Byte-valid mask covering lanes 0..lane inclusive.
  function automatic logic [KEEP_W-1:0] keep_upto(input logic [LANE_W-1:0] lane);
    keep_upto = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (i <= int'(lane)) keep_upto[i] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Small synchronous first-word-fall-through FIFO; dout shows the head entry
// whenever empty is low.
module word_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_q[gi] <= '0;
      end else if (wr_en && (wr_ptr_q == AW'(gi))) begin
        mem_q[gi] <= din;
      end
    end
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs the 8-bit pixel stream into little-endian 32-bit words, tags frame
// ends and partial flushes, and buffers words through a small FWFT FIFO.
module pixel_packer
  import pixel_stream_pkg::*;
#(
  parameter int PIXELS_PER_FRAME = 1024,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [7:0]  pixel_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] word_out,
  output logic [3:0]  word_keep,
  output logic        word_last,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_done
);

  localparam int PCW = (PIXELS_PER_FRAME > 1) ? $clog2(PIXELS_PER_FRAME) : 1;
  localparam logic [PCW-1:0]    PIX_LAST  = PCW'(PIXELS_PER_FRAME - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [LANE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [PCW-1:0]     pixel_cnt_q, pixel_cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               frame_done_q, frame_done_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic               accept, frame_end;
  logic [DATA_W-1:0]  pixel_word;

  // Ready depends only on registered state so it never loops back through valid_in.
  assign ready_out = (state_q == PACK) && !fifo_full;
  assign accept    = valid_in && ready_out;
  assign frame_end = (pixel_cnt_q == PIX_LAST);

  always_comb begin
    pixel_word = acc_q;
    pixel_word[{byte_cnt_q, 3'b000} +: 8] = pixel_in;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    byte_cnt_d   = byte_cnt_q;
    pixel_cnt_d  = pixel_cnt_q;
    flush_pend_d = flush_pend_q;
    fifo_push    = 1'b0;
    fifo_din     = '0;
    case (state_q)
      IDLE: begin
        if (start) state_d = PACK;
      end
      PACK: begin
        if (accept) begin
          acc_d       = pixel_word;
          byte_cnt_d  = byte_cnt_q + LANE_W'(1);
          pixel_cnt_d = frame_end ? '0 : pixel_cnt_q + PCW'(1);
          if ((byte_cnt_q == LANE_LAST) || frame_end) begin
            fifo_push                      = 1'b1;
            fifo_din[LAST_OFF]             = frame_end;
            fifo_din[KEEP_OFF +: KEEP_W]   = keep_upto(byte_cnt_q);
            fifo_din[DATA_OFF +: DATA_W]   = pixel_word;
            acc_d                          = '0;
            byte_cnt_d                     = '0;
          end
        end else if (flush_pend_q) begin
          // A pending flush only emits when no pixel competes for the push slot.
          if (byte_cnt_q == '0) begin
            flush_pend_d = 1'b0;
          end else if (!fifo_full) begin
            fifo_push                    = 1'b1;
            fifo_din[LAST_OFF]           = 1'b0;
            fifo_din[KEEP_OFF +: KEEP_W] = keep_upto(byte_cnt_q - LANE_W'(1));
            fifo_din[DATA_OFF +: DATA_W] = acc_q;
            acc_d                        = '0;
            byte_cnt_d                   = '0;
            flush_pend_d                 = 1'b0;
          end
        end
        if (flush) flush_pend_d = 1'b1;
        if (!start) begin
          state_d      = IDLE;
          acc_d        = '0;
          byte_cnt_d   = '0;
          pixel_cnt_d  = '0;
          flush_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_valid   = !fifo_empty;
  assign fifo_pop     = word_valid && word_ready;
  assign frame_done_d = fifo_pop && fifo_dout[LAST_OFF];

  assign word_out   = word_valid ? fifo_dout[DATA_OFF +: DATA_W] : '0;
  assign word_keep  = word_valid ? fifo_dout[KEEP_OFF +: KEEP_W] : '0;
  assign word_last  = word_valid && fifo_dout[LAST_OFF];
  assign frame_done = frame_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      byte_cnt_q   <= '0;
      pixel_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      byte_cnt_q   <= byte_cnt_d;
      pixel_cnt_q  <= pixel_cnt_d;
      flush_pend_q <= flush_pend_d;
      frame_done_q <= frame_done_d;
    end
  end

  word_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (fifo_din),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_pixel_packer.sv
// Drives two packers (1024-pixel and 6-pixel frames) with the same directed
// stimulus and checks both against a lane-list / word-queue model every cycle.
module tb_pixel_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, flush, valid_in, word_ready;
  logic [7:0] pixel_in;
  logic [1:0] ro, wv, wl, fd;
  logic [1:0][31:0] wo;
  logic [1:0][3:0]  wk;

  pixel_packer #(.PIXELS_PER_FRAME(1024), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .pixel_in(pixel_in),
    .valid_in(valid_in), .ready_out(ro[0]), .word_out(wo[0]), .word_keep(wk[0]),
    .word_last(wl[0]), .word_valid(wv[0]), .word_ready(word_ready), .frame_done(fd[0]));

  pixel_packer #(.PIXELS_PER_FRAME(6), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .pixel_in(pixel_in),
    .valid_in(valid_in), .ready_out(ro[1]), .word_out(wo[1]), .word_keep(wk[1]),
    .word_last(wl[1]), .word_valid(wv[1]), .word_ready(word_ready), .frame_done(fd[1]));

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_pack [2];
  int          m_nl   [2];
  logic [7:0]  m_lane [2][4];
  int          m_pix  [2];
  bit          m_pend [2];
  logic [36:0] m_fifo [2][4];
  int          m_cnt  [2];
  bit          m_fd   [2];
  bit          mb_room, mb_acc, mb_pop, mb_done, mb_push, mb_eof;
  logic [36:0] mb_ent;

  function automatic int ppf_of(input int k);
    return (k == 0) ? 1024 : 6;
  endfunction

  function automatic logic [36:0] mk_entry(input int k, input bit last);
    logic [31:0] data;
    logic [3:0]  keep;
    data = '0;
    keep = '0;
    for (int i = 0; i < m_nl[k]; i++) begin
      data = data | (32'(m_lane[k][i]) << (8 * i));
      keep[i] = 1'b1;
    end
    return {last, keep, data};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pack[k] = 0; m_nl[k] = 0; m_pix[k] = 0; m_pend[k] = 0;
        m_cnt[k] = 0; m_fd[k] = 0;
      end else begin
        mb_room = (m_cnt[k] < 4);
        mb_acc  = m_pack[k] && mb_room && valid_in;
        mb_pop  = (m_cnt[k] > 0) && word_ready;
        mb_done = mb_pop && m_fifo[k][0][36];
        mb_push = 0;
        mb_ent  = '0;
        if (m_pack[k]) begin
          if (mb_acc) begin
            mb_eof = (m_pix[k] == ppf_of(k) - 1);
            m_lane[k][m_nl[k]] = pixel_in;
            m_nl[k]++;
            m_pix[k] = mb_eof ? 0 : m_pix[k] + 1;
            if (m_nl[k] == 4 || mb_eof) begin
              mb_push = 1; mb_ent = mk_entry(k, mb_eof); m_nl[k] = 0;
            end
          end else if (m_pend[k]) begin
            if (m_nl[k] == 0) m_pend[k] = 0;
            else if (mb_room) begin
              mb_push = 1; mb_ent = mk_entry(k, 1'b0); m_nl[k] = 0; m_pend[k] = 0;
            end
          end
          if (flush) m_pend[k] = 1;
          if (!start) begin
            m_pack[k] = 0; m_nl[k] = 0; m_pix[k] = 0; m_pend[k] = 0;
          end
        end else if (start) begin
          m_pack[k] = 1;
        end
        if (mb_pop) begin
          for (int i = 0; i < 3; i++) m_fifo[k][i] = m_fifo[k][i+1];
          m_cnt[k]--;
        end
        if (mb_push) begin
          m_fifo[k][m_cnt[k]] = mb_ent;
          m_cnt[k]++;
        end
        m_fd[k] = mb_done;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("ready_out[%0d]", k), ro[k], (m_pack[k] && m_cnt[k] < 4));
        chk($sformatf("word_valid[%0d]", k), wv[k], (m_cnt[k] > 0));
        chk($sformatf("word[%0d]", k), {wl[k], wk[k], wo[k]},
            (m_cnt[k] > 0) ? m_fifo[k][0] : 37'd0);
        chk($sformatf("frame_done[%0d]", k), fd[k], m_fd[k]);
      end
    end
  end

  // ---------------- output log for literal checks ----------------
  logic [36:0] lg [2][64];
  int ln [2];
  int fd_cnt1 = 0;
  initial begin
    ln[0] = 0;
    ln[1] = 0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (wv[k] && word_ready && ln[k] < 64) begin
          lg[k][ln[k]] = {wl[k], wk[k], wo[k]};
          ln[k]++;
        end
      end
      if (fd[1]) fd_cnt1++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] p);
    int n;
    pixel_in = p;
    valid_in = 1'b1;
    n = 0;
    while (!ro[0] && n < 40) begin
      cyc();
      n++;
    end
    if (n >= 40) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got ready_out=0 for %0d cycles, required 1", n);
    end
    cyc();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  int b0, b1, fdb;

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; valid_in = 1'b0;
    pixel_in = 8'h00; word_ready = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    chk("reset_ready", ro[0], 0);
    chk("reset_valid", wv[0], 0);
    rst = 1'b0;

    // Test 1: back-to-back full words
    start = 1'b1; word_ready = 1'b1;
    cyc();
    for (int i = 1; i <= 8; i++) send(8'(i));
    valid_in = 1'b0;
    cyc(6);
    chk("t1_word0", lg[0][0], {1'b0, 4'hF, 32'h04030201});
    chk("t1_word1", lg[0][1], {1'b0, 4'hF, 32'h08070605});

    // Test 2: back-pressure fills the FIFO
    word_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(8'(8'h10 + i));
    pixel_in = 8'h21; valid_in = 1'b1;
    cyc(3);
    chk("t2_ready_low", ro[0], 0);
    word_ready = 1'b1;
    for (int i = 17; i <= 20; i++) send(8'(8'h10 + i));
    valid_in = 1'b0;
    cyc(8);
    chk("t2_count", ln[0], 7);
    chk("t2_first", lg[0][2], {1'b0, 4'hF, 32'h14131211});
    chk("t2_fifth", lg[0][6], {1'b0, 4'hF, 32'h24232221});

    // Test 3: flush of a partial word
    send(8'hAA); send(8'hBB);
    valid_in = 1'b0;
    pulse_flush();
    cyc(4);
    send(8'hCC);
    valid_in = 1'b0;
    pulse_flush();
    cyc(4);
    chk("t3_partial", lg[0][7], {1'b0, 4'b0011, 32'h0000BBAA});
    chk("t3_next", lg[0][8], {1'b0, 4'b0001, 32'h000000CC});

    // Test 4: frame end on the 6-pixel instance
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    b0 = ln[0]; b1 = ln[1]; fdb = fd_cnt1;
    for (int i = 1; i <= 7; i++) send(8'(i));
    valid_in = 1'b0;
    pulse_flush();
    cyc(6);
    chk("t4_word0", lg[1][b1], {1'b0, 4'hF, 32'h04030201});
    chk("t4_last", lg[1][b1+1], {1'b1, 4'b0011, 32'h00000605});
    chk("t4_next", lg[1][b1+2], {1'b0, 4'b0001, 32'h00000007});
    chk("t4_frame_done", fd_cnt1 - fdb, 1);
    chk("t4_dut0_flush", lg[0][b0+1], {1'b0, 4'b0111, 32'h00070605});

    // Test 5: stop mid-word with a word queued
    word_ready = 1'b0;
    b0 = ln[0];
    for (int i = 1; i <= 7; i++) send(8'(8'h40 + i));
    valid_in = 1'b0;
    cyc();
    start = 1'b0;
    cyc();
    word_ready = 1'b1;
    cyc(4);
    chk("t5_drained", lg[0][b0], {1'b0, 4'hF, 32'h44434241});
    chk("t5_one_word", ln[0] - b0, 1);
    start = 1'b1;
    cyc();
    for (int i = 1; i <= 4; i++) send(8'(8'h50 + i));
    valid_in = 1'b0;
    cyc(4);
    chk("t5_fresh", lg[0][b0+1], {1'b0, 4'hF, 32'h54535251});

    // Test 6: reset with words queued
    word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(8'h60 + i));
    valid_in = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("t6_valid", wv[0], 0);
    chk("t6_ready", ro[0], 0);
    chk("t6_word", wo[0], 0);
    chk("t6_frame_done", fd[0], 0);
    chk("t6_valid1", wv[1], 0);
    rst = 1'b0;
    word_ready = 1'b1;
    b0 = ln[0];
    cyc(6);
    chk("t6_no_stale", ln[0] - b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
